// File: rtl/cam_param_ternary_pkg.sv
// Shared defaults, index-width helper and entry layout for the parametrised
// ternary CAM.
package cam_param_ternary_pkg;

    localparam int unsigned CAM_DATA_W_DEF = 32;
    localparam int unsigned CAM_DEPTH_DEF  = 32;

    // Index width for a given depth; depth is a power of two and at least 2.
    function automatic int unsigned cam_idx_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // One CAM entry at the default width.
    typedef struct packed {
        logic                      valid;
        logic [CAM_DATA_W_DEF-1:0] data;
    } cam_entry_t;

endpackage

// File: rtl/cam_param_ternary_if.sv
// Request/response bundle for the ternary CAM. The requester drives the
// read/write/invalidate/search requests; the CAM returns registered results.
interface cam_param_ternary_if
    import cam_param_ternary_pkg::*;
#(
    parameter int unsigned DATA_W = CAM_DATA_W_DEF,
    parameter int unsigned DEPTH  = CAM_DEPTH_DEF
) ();

    localparam int unsigned IDX_W = cam_idx_w(DEPTH);

    logic              read_enable_i;
    logic [IDX_W-1:0]  read_index_i;
    logic              write_enable_i;
    logic [IDX_W-1:0]  write_index_i;
    logic [DATA_W-1:0] write_data_i;
    logic              invalidate_enable_i;
    logic [IDX_W-1:0]  invalidate_index_i;
    logic              search_enable_i;
    logic [DATA_W-1:0] search_data_i;
    logic [DATA_W-1:0] search_mask_i;

    logic              read_valid_o;
    logic [DATA_W-1:0] read_value_o;
    logic              search_valid_o;
    logic [IDX_W-1:0]  search_index_o;
    logic              search_multi_o;
    logic [IDX_W:0]    count_o;
    logic              full_o;

    modport master (
        output read_enable_i, read_index_i,
        output write_enable_i, write_index_i, write_data_i,
        output invalidate_enable_i, invalidate_index_i,
        output search_enable_i, search_data_i, search_mask_i,
        input  read_valid_o, read_value_o,
        input  search_valid_o, search_index_o, search_multi_o,
        input  count_o, full_o
    );

    modport slave (
        input  read_enable_i, read_index_i,
        input  write_enable_i, write_index_i, write_data_i,
        input  invalidate_enable_i, invalidate_index_i,
        input  search_enable_i, search_data_i, search_mask_i,
        output read_valid_o, read_value_o,
        output search_valid_o, search_index_o, search_multi_o,
        output count_o, full_o
    );

endinterface

// File: rtl/cam_param_ternary_prio_enc.sv
// Priority encoder over the CAM match vector: lowest matching index, any-hit
// and multi-hit flags. Purely combinational; the parent registers the result.
module cam_param_ternary_prio_enc #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned IDX_W = 5
) (
    input  logic [DEPTH-1:0] match_i,
    output logic [IDX_W-1:0] index_o,
    output logic             any_o,
    output logic             multi_o
);

    logic [IDX_W-1:0] idx;
    logic             any;
    logic             multi;

    // Ascending scan: the first hit fixes the index, any later hit sets multi.
    always_comb begin
        idx   = '0;
        any   = 1'b0;
        multi = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (match_i[i]) begin
                if (any) begin
                    multi = 1'b1;
                end else begin
                    idx = IDX_W'(i);
                end
                any = 1'b1;
            end
        end
    end

    assign index_o = idx;
    assign any_o   = any;
    assign multi_o = multi;

endmodule

// File: rtl/cam_param_ternary.sv
// Parametrised ternary CAM: per-entry valid bits, write/invalidate, masked
// search with priority resolution and multi-hit flag, and occupancy count.
// Read and search results appear one cycle after the request and reflect the
// contents before that cycle's write/invalidate.
module cam_param_ternary
    import cam_param_ternary_pkg::*;
#(
    parameter int unsigned DATA_W = CAM_DATA_W_DEF,
    parameter int unsigned DEPTH  = CAM_DEPTH_DEF
) (
    input logic             clk_i,
    input logic             rst_i,
    cam_param_ternary_if.slave bus
);

    localparam int unsigned    IDX_W      = cam_idx_w(DEPTH);
    localparam logic [IDX_W:0] COUNT_ONE  = {{IDX_W{1'b0}}, 1'b1};
    localparam logic [IDX_W:0] FULL_COUNT = (IDX_W + 1)'(DEPTH);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [IDX_W:0]    count_q, count_d;

    logic              read_valid_q, read_valid_d;
    logic [DATA_W-1:0] read_value_q, read_value_d;
    logic              search_valid_q, search_valid_d;
    logic [IDX_W-1:0]  search_index_q, search_index_d;
    logic              search_multi_q, search_multi_d;

    logic [DEPTH-1:0]  match;
    logic [IDX_W-1:0]  enc_index;
    logic              enc_any;
    logic              enc_multi;
    logic              wr_new;
    logic              inv_drop;

    // Ternary compare of every entry against the key, gated by the valid bit.
    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            match[i] = valid_q[i] &&
                       (((data_q[i] ^ bus.search_data_i) & bus.search_mask_i) == '0);
        end
    end

    cam_param_ternary_prio_enc #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .match_i (match),
        .index_o (enc_index),
        .any_o   (enc_any),
        .multi_o (enc_multi)
    );

    // Valid-bit and occupancy update. Invalidate is applied before write so a
    // same-index write wins; the count moves only on real valid transitions,
    // so a write and an invalidate that both change state cancel out.
    always_comb begin
        valid_d  = valid_q;
        count_d  = count_q;
        wr_new   = bus.write_enable_i && !valid_q[bus.write_index_i];
        inv_drop = bus.invalidate_enable_i && valid_q[bus.invalidate_index_i] &&
                   !(bus.write_enable_i &&
                     (bus.write_index_i == bus.invalidate_index_i));
        if (bus.invalidate_enable_i) begin
            valid_d[bus.invalidate_index_i] = 1'b0;
        end
        if (bus.write_enable_i) begin
            valid_d[bus.write_index_i] = 1'b1;
        end
        case ({wr_new, inv_drop})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Next values of the single-cycle read and search result pulses.
    always_comb begin
        read_valid_d   = 1'b0;
        read_value_d   = '0;
        search_valid_d = 1'b0;
        search_index_d = '0;
        search_multi_d = 1'b0;
        if (bus.read_enable_i && valid_q[bus.read_index_i]) begin
            read_valid_d = 1'b1;
            read_value_d = data_q[bus.read_index_i];
        end
        if (bus.search_enable_i) begin
            search_valid_d = enc_any;
            search_index_d = enc_index;
            search_multi_d = enc_multi;
        end
    end

    // Control state and result registers; reset drops valid bits and results.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q        <= '0;
            count_q        <= '0;
            read_valid_q   <= 1'b0;
            read_value_q   <= '0;
            search_valid_q <= 1'b0;
            search_index_q <= '0;
            search_multi_q <= 1'b0;
        end else begin
            valid_q        <= valid_d;
            count_q        <= count_d;
            read_valid_q   <= read_valid_d;
            read_value_q   <= read_value_d;
            search_valid_q <= search_valid_d;
            search_index_q <= search_index_d;
            search_multi_q <= search_multi_d;
        end
    end

    // Data storage is not reset; an entry's contents only matter once valid.
    always_ff @(posedge clk_i) begin
        if (bus.write_enable_i) begin
            data_q[bus.write_index_i] <= bus.write_data_i;
        end
    end

    assign bus.read_valid_o   = read_valid_q;
    assign bus.read_value_o   = read_value_q;
    assign bus.search_valid_o = search_valid_q;
    assign bus.search_index_o = search_index_q;
    assign bus.search_multi_o = search_multi_q;
    assign bus.count_o        = count_q;
    assign bus.full_o         = (count_q == FULL_COUNT);

endmodule

// File: doc/cam_param_ternary.md
Name: cam_param_ternary

Overview:
- Parametrised successor to the fixed 32x32 CAM.
- Adds configurable width and depth, per-entry valid bits, explicit invalidate, and a ternary (masked) search.
- Resolves multiple hits with a priority encoder, flags multi-hit, and tracks occupancy.
- Sits in CAM_Validation as the DUT behind the cam_interface bench; one clock domain.

Parameters:
DATA_W, 32, stored/search word width
DEPTH, 32, number of entries (power of two, >=2)
IDX_W, $clog2(DEPTH), index width (derived, not overridden)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  reset
read_enable_i  in  1  read request
read_index_i  in  IDX_W  read entry
write_enable_i  in  1  write request
write_index_i  in  IDX_W  write entry
write_data_i  in  DATA_W  write data
invalidate_enable_i  in  1  clear an entry's valid bit
invalidate_index_i  in  IDX_W  entry to invalidate
search_enable_i  in  1  search request
search_data_i  in  DATA_W  search key
search_mask_i  in  DATA_W  1=compare bit, 0=don't care
read_valid_o  out  1  read hit on valid entry
read_value_o  out  DATA_W  read data
search_valid_o  out  1  at least one match
search_index_o  out  IDX_W  lowest matching index
search_multi_o  out  1  two or more matches
count_o  out  IDX_W+1  number of valid entries
full_o  out  1  count_o==DEPTH

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_i=0):
  - Asynchronously clears all valid bits, count_o, and all outputs to 0.
  - Data array is not reset.
  - In-flight read/search results are discarded; no output pulse follows reset release.
- Read: latency 1.
  - Enable at cycle T gives read_valid_o=valid[idx] at T+1.
  - read_value_o = data[idx] if valid, else 0.
  - Without enable: read_valid_o=0, read_value_o=0 (single-cycle pulse, not held).
- Write: at edge, data[idx]<=write_data_i, valid[idx]<=1. Overwriting a valid entry is legal.
- Invalidate: at edge, valid[idx]<=0. Write and invalidate to the same index in the same cycle: write wins, entry valid.
- Search: latency 1, compares against pre-edge state.
  - Match[i] = valid[i] & ((data[i] ^ search_data_i) & search_mask_i)==0.
  - At T+1: search_valid_o=|match, search_index_o=lowest i with match (0 on miss), search_multi_o=popcount(match)>=2.
  - Without enable, all three outputs are 0.
  - All-zero mask matches every valid entry.
- Same-cycle hazards: read or search of an index written/invalidated in the same cycle returns OLD contents (no bypass). Read, write, invalidate and search may all occur in one cycle.
- count_o (registered):
  - +1 when a write targets an invalid entry.
  - -1 when an invalidate targets a valid entry at a different index from the same-cycle write.
  - Both events together: net 0.
  - Saturation is impossible by construction; full_o is combinational from count_o.
- Out-of-range index: none (DEPTH is a power of two).

Decomposition:
- cam_pkg: DATA_W/DEPTH defaults, IDX_W function, cam_entry_t struct {valid, data}.
- Sub-module cam_prio_enc: DEPTH-bit match vector in; lowest index, any, multi out; purely combinational, registered in the parent.

Test Plan:
- Reset, then write idx 3=0xDEADBEEF → next cycle count_o=1; read idx 3 → read_valid_o=1, read_value_o=0xDEADBEEF; read idx 4 → read_valid_o=0, value 0.
- Write idx 5 and idx 9 =0x0000_00AA; search 0xAA, mask 0xFFFFFFFF → search_valid_o=1, search_index_o=5, search_multi_o=1.
- Write idx 7=0x1234_5678; search 0x1234_0000, mask 0xFFFF_0000 → hit idx 7; search same key with full mask → search_valid_o=0.
- Invalidate idx 5 while writing idx 5=0x11 in the same cycle → entry valid, count unchanged. Then invalidate idx 5 alone → count decrements; search 0x11 full mask → miss.
- Write idx 2=0x55 and search 0x55 in the same cycle on an empty CAM → search misses. Repeat the search next cycle → hit idx 2.
- Fill all 32 entries → full_o=1, count_o=32. Assert rst_i low mid-search → search_valid_o=0 immediately, count_o=0, full_o=0; after release, read idx 0 → read_valid_o=0.
